stage_ex: RTL

Execute stage with integrated EX/MEM pipeline register. It sits directly upstream of stage_MEM and drives its alu_result, store_data, rd_addr_in, reg_wen_in, mem_wen, is_mem_inst and is_load inputs from registered outputs.
Single-cycle ALU operations complete in one clock. MUL uses an iterative shift-add multiplier that takes DATA_WIDTH cycles and stalls the upstream ID/EX register while busy.

---
 rtl/stage_ex.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/stage_ex.sv
// -----------------------------------------------------------------------------
// stage_ex -- execute stage with integrated EX/MEM pipeline register.
//
// Single-cycle ALU operations are registered into EX/MEM on the edge that
// accepts them. MUL is computed by an iterative shift-add multiplier that
// takes DATA_WIDTH cycles after acceptance. While it runs, stall_out holds the
// ID/EX register and earlier stages.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid, flush   ID/EX instruction valid / kill this cycle's instruction
//   alu_op            operation select (0 ADD .. 11 MUL, 12-15 -> 0)
//   op_a, op_b        operands
//   store_data_in     STR source data
//   rd_addr_in, reg_wen_in, mem_wen_in, is_mem_inst_in, is_load_in
//                     control travelling with the instruction
//   stall_out         high while a multiply is in progress
//   ex_valid          EX/MEM holds a valid instruction
//   alu_result        result, or byte address for LDR/STR
//   store_data, rd_addr_out, reg_wen_out, mem_wen, is_mem_inst, is_load
//                     registered control, zero for a bubble
// -----------------------------------------------------------------------------
module stage_ex #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic                      flush,
    input  logic [3:0]                alu_op,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    input  logic [DATA_WIDTH-1:0]     store_data_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
    input  logic                      reg_wen_in,
    input  logic                      mem_wen_in,
    input  logic                      is_mem_inst_in,
    input  logic                      is_load_in,
    output logic                      stall_out,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     alu_result,
    output logic [DATA_WIDTH-1:0]     store_data,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_out,
    output logic                      reg_wen_out,
    output logic                      mem_wen,
    output logic                      is_mem_inst,
    output logic                      is_load
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    // The counter only needs to reach DATA_WIDTH-1, so it fits in SHAMT_W bits.
    localparam int CNT_W   = SHAMT_W;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_SLL    = 4'd5;
    localparam logic [3:0] OP_SRL    = 4'd6;
    localparam logic [3:0] OP_SRA    = 4'd7;
    localparam logic [3:0] OP_SLT    = 4'd8;
    localparam logic [3:0] OP_SLTU   = 4'd9;
    localparam logic [3:0] OP_PASS_B = 4'd10;
    localparam logic [3:0] OP_MUL    = 4'd11;

    // Everything that travels alongside the result into EX/MEM.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      reg_wen;
        logic                      mem_wen;
        logic                      is_mem_inst;
        logic                      is_load;
    } ctl_t;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [CNT_W-1:0]      mul_cnt;
    ctl_t                  mul_ctl;
    ctl_t                  in_ctl;

    logic [DATA_WIDTH-1:0] alu_out;
    logic [SHAMT_W-1:0]    shamt;
    logic                  lt_signed;
    logic                  lt_unsigned;

    logic [DATA_WIDTH-1:0] partial;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic                  mul_last;
    logic                  accept_mul;

    logic                  nxt_valid;
    logic [DATA_WIDTH-1:0] nxt_result;
    ctl_t                  nxt_ctl;

    assign in_ctl = '{
        store_data:  store_data_in,
        rd_addr:     rd_addr_in,
        reg_wen:     reg_wen_in,
        mem_wen:     mem_wen_in,
        is_mem_inst: is_mem_inst_in,
        is_load:     is_load_in
    };

    // stall_out comes straight from the state register so upstream stages see
    // no combinational path from this cycle's inputs.
    assign stall_out = (state == ST_MUL_BUSY);

    // -------------------------------------------------------------------------
    // Single-cycle ALU
    // -------------------------------------------------------------------------
    assign shamt       = op_b[SHAMT_W-1:0];
    assign lt_signed   = ($signed(op_a) < $signed(op_b));
    assign lt_unsigned = (op_a < op_b);

    always_comb begin
        // NOTE: every path through always_comb must assign its outputs; the
        // default up front prevents an inferred latch for unlisted opcodes.
        alu_out = '0;
        case (alu_op)
            OP_ADD:    alu_out = op_a + op_b;
            OP_SUB:    alu_out = op_a - op_b;
            OP_AND:    alu_out = op_a & op_b;
            OP_OR:     alu_out = op_a | op_b;
            OP_XOR:    alu_out = op_a ^ op_b;
            OP_SLL:    alu_out = op_a << shamt;
            OP_SRL:    alu_out = op_a >> shamt;
            OP_SRA:    alu_out = $signed(op_a) >>> shamt;
            OP_SLT:    alu_out = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU:   alu_out = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
            OP_PASS_B: alu_out = op_b;
            default:   alu_out = '0;   // MUL is handled iteratively; 12-15 give 0
        endcase
    end

    // -------------------------------------------------------------------------
    // Shift-add multiplier step
    // -------------------------------------------------------------------------
    // Only the low DATA_WIDTH bits of the product are needed, so bits shifted
    // out of the multiplicand can simply be dropped.
    assign partial  = mplier[0] ? mcand : '0;
    assign acc_sum  = acc + partial;
    assign mul_last = (mul_cnt == CNT_W'(DATA_WIDTH - 1));

    // -------------------------------------------------------------------------
    // Next EX/MEM contents: a bubble unless something completes this edge.
    // -------------------------------------------------------------------------
    always_comb begin
        nxt_valid  = 1'b0;
        nxt_result = '0;
        nxt_ctl    = '0;
        accept_mul = 1'b0;
        case (state)
            ST_IDLE: begin
                if (id_valid && !flush) begin
                    if (alu_op == OP_MUL) begin
                        accept_mul = 1'b1;
                    end else begin
                        nxt_valid  = 1'b1;
                        nxt_result = alu_out;
                        nxt_ctl    = in_ctl;
                    end
                end
            end
            ST_MUL_BUSY: begin
                // Inputs are ignored here; the held instruction is accepted
                // in the first IDLE cycle.
                if (mul_last) begin
                    nxt_valid  = 1'b1;
                    nxt_result = acc_sum;
                    nxt_ctl    = mul_ctl;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (accept_mul) state <= ST_MUL_BUSY;
                ST_MUL_BUSY: if (mul_last)   state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Multiplier registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, so a multiply cut off
        // by reset leaves no partial product behind.
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mul_cnt <= '0;
            mul_ctl <= '0;
        end else if (accept_mul) begin
            mcand   <= op_a;
            mplier  <= op_b;
            acc     <= '0;
            mul_cnt <= '0;
            mul_ctl <= in_ctl;
        end else if (state == ST_MUL_BUSY) begin
            acc     <= acc_sum;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // EX/MEM pipeline register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            alu_result  <= '0;
            store_data  <= '0;
            rd_addr_out <= '0;
            reg_wen_out <= 1'b0;
            mem_wen     <= 1'b0;
            is_mem_inst <= 1'b0;
            is_load     <= 1'b0;
        end else begin
            ex_valid    <= nxt_valid;
            alu_result  <= nxt_result;
            store_data  <= nxt_ctl.store_data;
            rd_addr_out <= nxt_ctl.rd_addr;
            reg_wen_out <= nxt_ctl.reg_wen;
            mem_wen     <= nxt_ctl.mem_wen;
            is_mem_inst <= nxt_ctl.is_mem_inst;
            is_load     <= nxt_ctl.is_load;
        end
    end

endmodule
